// File: rtl/adder_carry_seq.sv
// Purpose: multi-cycle N-bit add/subtract, W bits per clock, carry held in a register between chunks.
// Latency: result and done_tick appear K=N/W cycles after the accepting edge; one op per K+2 cycles.
// Backpressure: start is taken only while ready=1; start while busy is dropped, never queued.
//
// Ports:
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   start, sub, cin     request strobe, subtract select (a-b, cin ignored), add carry-in
//   a, b                N-bit operands, sampled on the accepting edge
//   ready, done_tick    idle indicator, one-cycle "result just updated" pulse (both Moore)
//   sum, cout, ovf      registered result, carry-out (1 = no borrow on subtract), signed overflow
//
// N must be an integer multiple of W.

module adder_carry_seq #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int K  = N / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  s_reg;
  logic          c_reg;
  logic [CW-1:0] idx;

  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic [W-1:0]  s_chunk;
  logic          c_chunk;
  logic [N-1:0]  s_merged;
  logic          last_chunk;

  // One W-bit slice of the datapath. The sum is formed in W+1 bits so the
  // carry out of the chunk is kept intact for the next cycle.
  always_comb begin
    a_chunk  = a_reg[idx*W +: W];
    b_chunk  = b_reg[idx*W +: W];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, c_reg};
    // Working result with the current chunk already in place, so the final
    // edge can load sum directly without waiting one more cycle.
    s_merged = s_reg;
    s_merged[idx*W +: W] = s_chunk;
    last_chunk = (idx == LAST_IDX);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_OP;
      S_OP:    if (last_chunk) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: no combinational path from any input.
  assign ready     = (state == S_IDLE);
  assign done_tick = (state == S_DONE);

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      c_reg <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b once here and seed the carry.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            c_reg <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        S_OP: begin
          s_reg <= s_merged;
          c_reg <= c_chunk;
          if (last_chunk) begin
            sum  <= s_merged;
            cout <= c_chunk;
            // Overflow compares against the effective (possibly inverted) b.
            ovf  <= (a_reg[N-1] == b_reg[N-1]) && (s_chunk[W-1] != a_reg[N-1]);
          end else begin
            idx <= idx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_carry_seq.sv
module tb_adder_carry_seq;

  logic        clk;
  logic        reset_n;
  logic        sub_i, cin_i;
  logic [31:0] a_i, b_i;

  logic        start8, start16, start32;
  logic        ready8, ready16, ready32;
  logic        done8, done16, done32;
  logic        cout8, cout16, cout32;
  logic        ovf8, ovf16, ovf32;
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic [31:0] sum32;

  int n_tests = 0;
  int n_fail  = 0;

  adder_carry_seq #(.N(16), .W(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .sub(sub_i), .cin(cin_i),
    .a(a_i[15:0]), .b(b_i[15:0]), .ready(ready16), .done_tick(done16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  adder_carry_seq #(.N(8), .W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sub(sub_i), .cin(cin_i),
    .a(a_i[7:0]), .b(b_i[7:0]), .ready(ready8), .done_tick(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  adder_carry_seq #(.N(32), .W(8)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .sub(sub_i), .cin(cin_i),
    .a(a_i), .b(b_i), .ready(ready32), .done_tick(done32),
    .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: plain integer add/subtract on the operand values,
  // unsigned range for carry/borrow and signed range for overflow.
  function automatic void model(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic cin,
                                output logic [31:0] s, output logic co, output logic ov);
    longint m, av, bv, tot, lim, sa, sb, sres;
    m   = (longint'(1) << n) - 1;
    av  = longint'({32'd0, a}) & m;
    bv  = longint'({32'd0, b}) & m;
    tot = sub ? (av - bv) : (av + bv + longint'(cin));
    s   = 32'(tot & m);
    co  = sub ? (av >= bv) : (tot > m);
    lim = longint'(1) << (n - 1);
    sa  = (av >= lim) ? av - (lim << 1) : av;
    sb  = (bv >= lim) ? bv - (lim << 1) : bv;
    sres = sub ? (sa - sb) : (sa + sb + longint'(cin));
    ov  = (sres >= lim) || (sres < -lim);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      8:       start8  = v;
      16:      start16 = v;
      default: start32 = v;
    endcase
  endtask

  task automatic get(input int w, output logic rdy, output logic dn, output logic co,
                     output logic ov, output logic [31:0] s);
    case (w)
      8:       begin rdy = ready8;  dn = done8;  co = cout8;  ov = ovf8;  s = {24'd0, sum8};  end
      16:      begin rdy = ready16; dn = done16; co = cout16; ov = ovf16; s = {16'd0, sum16}; end
      default: begin rdy = ready32; dn = done32; co = cout32; ov = ovf32; s = sum32;          end
    endcase
  endtask

  // Runs one operation on the selected instance from idle back to idle and
  // checks latency, handshake and result against the reference model.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin,
                       output logic [31:0] s, output logic co, output logic ov);
    logic rdy, dn;
    logic [31:0] es;
    logic eco, eov;
    int lat;
    int k;
    k = (w == 8) ? 1 : 4;
    a_i = a; b_i = b; sub_i = sub; cin_i = cin;
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    a_i = $urandom; b_i = $urandom; sub_i = ~sub; cin_i = ~cin;
    get(w, rdy, dn, co, ov, s);
    check("busy_after_accept", rdy, 1'b0);
    lat = 0;
    while (!dn && lat < 40) begin
      tick();
      lat++;
      get(w, rdy, dn, co, ov, s);
      check("ready_low_busy", rdy, 1'b0);
    end
    check("done_seen", dn, 1'b1);
    check("latency", lat, k);
    model(w, a, b, sub, cin, es, eco, eov);
    check("sum_model", s, es);
    check("cout_model", co, eco);
    check("ovf_model", ov, eov);
    tick();
    get(w, rdy, dn, co, ov, s);
    check("done_one_cycle", dn, 1'b0);
    check("ready_after_done", rdy, 1'b1);
  endtask

  initial begin
    logic [31:0] s;
    logic co, ov, rdy, dn;
    int ndone;
    int last_cyc;
    int gaps_bad;
    int waited;

    reset_n = 1'b0;
    start8 = 1'b1; start16 = 1'b1; start32 = 1'b1;
    a_i = $urandom; b_i = $urandom; sub_i = 1'b0; cin_i = 1'b1;

    // Reset held with busy inputs: everything must sit at the idle/zero state.
    for (int i = 0; i < 3; i++) begin
      tick();
      a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom); cin_i = 1'($urandom);
    end
    check("rst_sum", sum16, 16'h0);
    check("rst_cout", cout16, 1'b0);
    check("rst_ovf", ovf16, 1'b0);
    check("rst_done", done16, 1'b0);
    check("rst_ready", ready16, 1'b1);
    check("rst_ready8", ready8, 1'b1);
    check("rst_ready32", ready32, 1'b1);

    // Release; the very next edge accepts.
    start8 = 1'b0; start32 = 1'b0;
    reset_n = 1'b1;
    do_op(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, s, co, ov);
    check("wrap_sum", s, 32'h0000);
    check("wrap_cout", co, 1'b1);
    check("wrap_ovf", ov, 1'b0);

    do_op(16, 32'h0FFF, 32'h0001, 1'b0, 1'b1, s, co, ov);
    check("cin_sum", s, 32'h1001);
    check("cin_cout", co, 1'b0);

    do_op(16, 32'h8000, 32'h0001, 1'b1, 1'b0, s, co, ov);
    check("subovf_sum", s, 32'h7FFF);
    check("subovf_cout", co, 1'b1);
    check("subovf_ovf", ov, 1'b1);

    do_op(16, 32'h0003, 32'h0005, 1'b1, 1'b1, s, co, ov);
    check("borrow_sum", s, 32'hFFFE);
    check("borrow_cout", co, 1'b0);
    check("borrow_ovf", ov, 1'b0);

    // start with new operands during op and done must be ignored.
    a_i = 32'h1111; b_i = 32'h2222; sub_i = 1'b0; cin_i = 1'b0;
    start16 = 1'b1;
    tick();
    a_i = 32'hAAAA; b_i = 32'h5555; sub_i = 1'b1; cin_i = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (done16) ndone++;
      if (i < 4) check("hold_prev_sum", sum16, 16'hFFFE);
    end
    check("busy_done_now", done16, 1'b1);
    check("busy_sum", sum16, 16'h3333);
    tick();
    start16 = 1'b0;
    check("busy_back_idle", ready16, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done16) ndone++;
    end
    check("busy_one_done", ndone, 1);
    check("busy_sum_stable", sum16, 16'h3333);

    // start held high: a new op every K+2 = 6 cycles.
    a_i = 32'h0001; b_i = 32'h0002; sub_i = 1'b0; cin_i = 1'b0;
    start16 = 1'b1;
    ndone = 0; last_cyc = -1; gaps_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done16) begin
        if (last_cyc >= 0 && (c - last_cyc) != 6) gaps_bad++;
        last_cyc = c;
        ndone++;
      end
    end
    start16 = 1'b0;
    check("stream_gaps", gaps_bad, 0);
    check("stream_count", ndone, 6);
    waited = 0;
    while (!ready16 && waited < 20) begin
      tick();
      waited++;
    end
    check("stream_idle", ready16, 1'b1);
    check("stream_sum", sum16, 16'h0003);

    // Reset in the middle of an operation.
    a_i = 32'h1234; b_i = 32'h1111; sub_i = 1'b0; cin_i = 1'b0;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_sum", sum16, 16'h0);
    check("midrst_cout", cout16, 1'b0);
    check("midrst_ovf", ovf16, 1'b0);
    check("midrst_ready", ready16, 1'b1);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done16) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    reset_n = 1'b1;
    do_op(16, 32'h1234, 32'h1111, 1'b0, 1'b0, s, co, ov);
    check("midrst_fresh_sum", s, 32'h2345);

    // Random sweeps: K=1, K=4 with W=8, and the default configuration.
    for (int i = 0; i < 1000; i++)
      do_op(8, $urandom, $urandom, 1'($urandom), 1'($urandom), s, co, ov);
    for (int i = 0; i < 1000; i++)
      do_op(32, $urandom, $urandom, 1'($urandom), 1'($urandom), s, co, ov);
    for (int i = 0; i < 200; i++)
      do_op(16, $urandom, $urandom, 1'($urandom), 1'($urandom), s, co, ov);

    get(16, rdy, dn, co, ov, s);
    check("final_idle", rdy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_carry_seq.md
# adder_carry_seq

Parametrised multi-cycle adder/subtractor that computes an N-bit sum W bits per clock, propagating the carry through a register between chunks. It trades latency for a narrow W-bit carry chain. It uses a start/ready/done_tick handshake, so it drops into FSMD datapaths that already use that protocol. It also adds carry-in, subtract mode and signed-overflow detection.

## Interface
- N, default 16: operand/result width; must be an integer multiple of W.
- W, default 4: chunk width processed per cycle; K = N/W chunks (K >= 1).
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- sub  input  1  0: a+b+cin; 1: a-b (cin ignored).
- cin  input  1  carry-in for add mode.
- a  input  N  operand A, sampled on accepting edge.
- b  input  N  operand B, sampled on accepting edge.
- ready  output  1  high in idle state.
- done_tick  output  1  one-cycle pulse: result registers just updated.
- sum  output  N  registered result.
- cout  output  1  carry-out (subtract: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

## Operation
- States:
  - idle: ready=1. On an edge with start=1 and ready=1:
    - latch a_reg=a;
    - b_reg=sub ? ~b : b;
    - c_reg=sub ? 1 : cin;
    - chunk index i=0; go to op.
  - op: each edge processes chunk i, computing {c, s} = a_reg[i*W+:W] + b_reg[i*W+:W] + c_reg, in W+1 bits, with no truncation before the carry is taken.
    - Write s into working register s_reg[i*W+:W]; c_reg=c; i=i+1.
    - On the edge processing chunk K-1: load sum=s_reg with the final chunk merged, cout=final carry, ovf=(a_reg[N-1]==b_reg[N-1]) && (result[N-1]!=a_reg[N-1]); go to done.
  - done: done_tick=1, ready=0; next edge go to idle.
- sum/cout/ovf change only on the op→done edge and hold until the next completed operation; partial results never appear on outputs.
- start while not ready is ignored, not queued. Changes to a/b/sub/cin after acceptance have no effect.
- Chunk counter is ceil(log2(K)) bits, minimum 1. It does not wrap; it resets to 0 on each acceptance.
- K=1 degenerates to one op cycle; behaviour is otherwise identical.
- Reset (reset_n=0 at any time, including mid-op): state=idle, s_reg/a_reg/b_reg/c_reg/i=0, sum=0, cout=0, ovf=0, done_tick=0, ready=1. The in-flight operation is discarded with no done_tick.

## Timing
- ready and done_tick are Moore outputs, decoded from the state register; there is no combinational path from inputs.
- Accept edge E0. Chunks are processed on edges E1..EK. Results are valid and done_tick=1 in the cycle after EK, which is K cycles after E0. The block returns to idle on EK+1.
- Maximum throughput: one operation per K+2 cycles. start held high continuously starts a new operation in the first idle cycle after each done cycle.
- Critical path: one W-bit adder plus mux, independent of N.
- Reset deassertion: the first edge with reset_n=1 may already accept start.

## Test plan
- Reset: hold reset_n=0 with random inputs and start=1. Require sum=0, cout=0, ovf=0, done_tick=0, ready=1. Release reset; the next edge accepts start.
- Wrap/carry (N=16, W=4): a=0xFFFF, b=0x0001, cin=0, sub=0. Require done_tick exactly 4 cycles after accept, sum=0x0000, cout=1, ovf=0, ready=0 during op/done. Then a=0x0FFF, b=0x0001, cin=1: require sum=0x1001, cout=0.
- Subtract/overflow: a=0x8000, b=0x0001, sub=1. Require sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1: require sum=0xFFFE, cout=0, ovf=0.
- Busy/hold: assert start with new operands during op and during done. Require no effect on the current result and exactly one done_tick. Previous sum must stay stable until the next completion. With start held high, done_ticks occur every 6 cycles.
- Reset mid-op: accept a=0x1234, b=0x1111, pull reset_n low after 2 op cycles. Require immediate zero outputs, ready=1, and no done_tick. A fresh operation afterward gives the correct result, 0x2345.
- Parameter sweep: N=8/W=8 (K=1, done_tick 1 cycle after accept) and N=32/W=8. Run 1000 random add/sub operations against a reference model for sum, cout and ovf.
